bar_digit_encoder: RTL and testbench
====================================

Name: bar_digit_encoder

Overview:
Producer side of the status-bar digit path for one car. Once per frame it snapshots the car's velocity, mass level and lap state and converts them into 4-bit digit codes. The codes are the hundred/ten/one velocity digits, the lap digit and the level digit, which the bar-digit renderer consumes. One instance serves CAR1 and one serves CAR2. The block also owns the car's saturating lap counter and the race-finished flag.

Parameters:
VEL_WIDTH, 10, width of two's-complement Q4.6 velocity input (integer 4 + fraction 6)
VEL_SHIFT, 3, right shift applied to the velocity magnitude to get display speed
SPEED_W, VEL_WIDTH-VEL_SHIFT, display-speed width; must satisfy 2^(VEL_WIDTH-1)>>VEL_SHIFT <= 999
LAP_MAX, 3, lap count at which the race is finished
LEVEL_W, 2, mass-level input width (levels 0..2)
DIGIT_W, 4, digit code width
BLANK_CODE, 4'hF, digit code the renderer draws as background

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_frame_start  in  1  one-cycle pulse; requests a new snapshot and conversion
i_velocity  in  VEL_WIDTH  signed Q4.6 car velocity
i_level  in  LEVEL_W  car mass level 0..2
i_lap_inc  in  1  one-cycle pulse on a valid finish-line crossing
i_clear  in  1  synchronous game restart; clears the lap counter and finished flag
o_busy  out  1  conversion in progress
o_valid  out  1  one-cycle pulse when all digit outputs have just updated
o_vel_hundred  out  DIGIT_W  velocity hundreds digit, or BLANK_CODE
o_vel_ten  out  DIGIT_W  velocity tens digit, or BLANK_CODE
o_vel_one  out  DIGIT_W  velocity ones digit (never blank)
o_lap_digit  out  DIGIT_W  completed laps, 0..LAP_MAX
o_level_digit  out  DIGIT_W  displayed level, i_level+1
o_finished  out  1  high while lap count == LAP_MAX

Behaviour:
- Reset values:
  - o_busy=0, o_valid=0
  - o_vel_hundred=BLANK_CODE, o_vel_ten=BLANK_CODE, o_vel_one=0
  - o_lap_digit=0, o_level_digit=1, o_finished=0
  - FSM in IDLE, lap counter=0
- FSM states and transitions:
  - IDLE: on i_frame_start, capture the snapshot and go to SHIFT.
  - SHIFT: runs exactly SPEED_W cycles.
  - DONE: one cycle, then back to IDLE.
- Snapshot captured on i_frame_start in IDLE:
  - magnitude = |i_velocity|, as an unsigned VEL_WIDTH value. The most negative input (-8.0, 10'h200) gives magnitude 512.
  - speed = magnitude >> VEL_SHIFT, truncated toward zero, taken as SPEED_W bits.
  - Also capture the level, and the lap count as of that edge.
- SHIFT: iterative double-dabble into 12 bits of BCD, one bit per cycle.
- DONE: registers every digit output simultaneously and pulses o_valid for that single cycle.
- Latency: i_frame_start sampled at edge N -> outputs update and o_valid=1 in the cycle after edge N+SPEED_W+1. The default is 8 edges after capture.
- o_busy=1 in SHIFT and DONE.
- Digit outputs are held constant between o_valid pulses; the renderer may sample them at any time.
- i_frame_start while o_busy=1 is ignored. There is no queueing, and the in-flight conversion is unaffected.
- Blanking:
  - hundred = BLANK_CODE if the BCD hundreds is 0.
  - ten = BLANK_CODE if both hundreds and tens are 0.
  - one is always numeric.
- Level: o_level_digit = i_level+1; i_level=3 is clamped to digit 3.
- Lap counter:
  - Saturating increment on i_lap_inc; no change at LAP_MAX.
  - o_finished is driven directly from the counter, with no frame latency.
  - o_lap_digit shows the value snapshotted at frame start.
- i_clear has priority over i_lap_inc in the same cycle. It clears the counter and o_finished next cycle; o_lap_digit shows 0 at the next completed conversion. A conversion in flight is not aborted.
- i_lap_inc coinciding with the i_frame_start capture edge: the snapshot takes the pre-increment count.
- i_rst asserted mid-conversion: the FSM returns to IDLE immediately and all outputs take their reset values. No o_valid is issued.

Decomposition:
- Shared package gets:
  - LAP_MAX
  - SINGLE_DIGIT_WIDTH
  - BLANK_CODE constant
  - VELOCITY_OUTPUT_WIDTH-derived SPEED_W default
  - state enum typedef {ENC_IDLE, ENC_SHIFT, ENC_DONE}
- Sub-module speed_bcd_converter: iterative double-dabble with start/busy/done handshake and SPEED_W parameter.
- Top level holds the snapshot registers, lap counter, blanking logic and output registers.

Test Plan:
- Reset, then i_velocity=10'h1C0 (+7.0), i_level=0, frame_start -> after 8 cycles o_valid=1; hundred=F, ten=5, one=6 (56); level digit=1.
- i_velocity=10'h200 (-8.0) -> speed 64 -> F,6,4. Then i_velocity=0 -> F,F,0. Then 10'h1FF -> F,6,3.
- VEL_SHIFT=0 instance, i_velocity=10'h200 -> 5,1,2 after SPEED_W+1 cycles; 10'h3FF (-1/64) -> F,F,1.
- Four i_lap_inc pulses -> count 1,2,3,3; o_finished=1 after the third. Next frame gives o_lap_digit=3. i_clear together with i_lap_inc -> count 0, o_finished=0.
- frame_start repeated on cycles 1..5 of a conversion -> exactly one o_valid, and digits reflect the first snapshot.
- Assert i_rst during SHIFT cycle 4 -> all outputs at reset values immediately, no o_valid. After release, a new frame_start converts normally.

Source files
------------

// File: rtl/bar_digit_encoder_pkg.sv
// Shared constants and types for the status-bar digit encoder.
// The SPEED_W default is derived from the velocity input width and the display shift.
package bar_digit_encoder_pkg;

  localparam int LAP_MAX               = 3;
  localparam int SINGLE_DIGIT_WIDTH    = 4;
  localparam logic [SINGLE_DIGIT_WIDTH-1:0] BLANK_CODE = 4'hF;

  localparam int VELOCITY_INPUT_WIDTH  = 10;
  localparam int VELOCITY_SHIFT        = 3;
  localparam int VELOCITY_OUTPUT_WIDTH = VELOCITY_INPUT_WIDTH - VELOCITY_SHIFT;
  localparam int SPEED_W_DEFAULT       = VELOCITY_OUTPUT_WIDTH;

  // Three BCD digits cover every display speed up to 999.
  localparam int BCD_W = 3 * SINGLE_DIGIT_WIDTH;

  typedef enum logic [1:0] {
    ENC_IDLE,
    ENC_SHIFT,
    ENC_DONE
  } enc_state_t;

endpackage

// File: rtl/bar_digit_encoder_speed_bcd_converter.sv
// Iterative double-dabble: converts SPEED_W binary bits into 12-bit BCD, one bit per clock.
// done is high during the cycle whose closing edge shifts in the final bit.
module speed_bcd_converter
  import bar_digit_encoder_pkg::*;
#(
  parameter int SPEED_W = SPEED_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SPEED_W-1:0] speed,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  localparam int CNT_W = $clog2(SPEED_W + 1);

  logic [SPEED_W-1:0] shift_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [BCD_W-1:0]   adjusted;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  for (genvar gi = 0; gi < BCD_W / 4; gi++) begin : g_adjust
    assign adjusted[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                 bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bcd_reg   <= '0;
      count_reg <= '0;
    end else if (start) begin
      shift_reg <= speed;
      bcd_reg   <= '0;
      count_reg <= CNT_W'(SPEED_W);
    end else if (count_reg != '0) begin
      bcd_reg   <= {adjusted[BCD_W-2:0], shift_reg[SPEED_W-1]};
      shift_reg <= {shift_reg[SPEED_W-2:0], 1'b0};
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign busy = (count_reg != '0);
  assign done = (count_reg == CNT_W'(1));
  assign bcd  = bcd_reg;

endmodule

// File: rtl/bar_digit_encoder.sv
// Per-car status-bar digit producer: snapshots velocity/level/laps each frame,
// converts speed to blanked BCD digits, and owns the saturating lap counter.
module bar_digit_encoder #(
  parameter int                VEL_WIDTH  = bar_digit_encoder_pkg::VELOCITY_INPUT_WIDTH,
  parameter int                VEL_SHIFT  = bar_digit_encoder_pkg::VELOCITY_SHIFT,
  parameter int                SPEED_W    = VEL_WIDTH - VEL_SHIFT,
  parameter int                LAP_MAX    = bar_digit_encoder_pkg::LAP_MAX,
  parameter int                LEVEL_W    = 2,
  parameter int                DIGIT_W    = bar_digit_encoder_pkg::SINGLE_DIGIT_WIDTH,
  parameter logic [DIGIT_W-1:0] BLANK_CODE = bar_digit_encoder_pkg::BLANK_CODE
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_frame_start,
  input  logic [VEL_WIDTH-1:0] i_velocity,
  input  logic [LEVEL_W-1:0]   i_level,
  input  logic                 i_lap_inc,
  input  logic                 i_clear,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic [DIGIT_W-1:0]   o_vel_hundred,
  output logic [DIGIT_W-1:0]   o_vel_ten,
  output logic [DIGIT_W-1:0]   o_vel_one,
  output logic [DIGIT_W-1:0]   o_lap_digit,
  output logic [DIGIT_W-1:0]   o_level_digit,
  output logic                 o_finished
);

  import bar_digit_encoder_pkg::*;

  enc_state_t state_reg, state_next;
  logic start;
  logic conv_busy, conv_done;
  logic [BCD_W-1:0] bcd;

  logic [VEL_WIDTH-1:0] magnitude;
  logic [SPEED_W-1:0]   speed;
  logic [DIGIT_W-1:0]   level_code;

  logic [DIGIT_W-1:0] lap_count_reg;
  logic [DIGIT_W-1:0] lap_snap_reg;
  logic [DIGIT_W-1:0] level_snap_reg;

  logic               valid_reg;
  logic [DIGIT_W-1:0] hundred_reg, ten_reg, one_reg, lap_digit_reg, level_digit_reg;
  logic               hundred_blank, ten_blank;

  // Unsigned magnitude keeps the most negative input (-8.0) as 512.
  assign magnitude  = i_velocity[VEL_WIDTH-1] ? -i_velocity : i_velocity;
  assign speed      = SPEED_W'(magnitude >> VEL_SHIFT);
  assign level_code = (i_level == LEVEL_W'(3)) ? DIGIT_W'(3) : DIGIT_W'(i_level) + DIGIT_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= ENC_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    case (state_reg)
      ENC_IDLE: begin
        if (i_frame_start) begin
          start      = 1'b1;
          state_next = ENC_SHIFT;
        end
      end
      ENC_SHIFT: begin
        if (conv_done || !conv_busy) begin
          state_next = ENC_DONE;
        end
      end
      ENC_DONE: state_next = ENC_IDLE;
      default:  state_next = ENC_IDLE;
    endcase
  end

  speed_bcd_converter #(
    .SPEED_W(SPEED_W)
  ) u_conv (
    .clk  (i_clk),
    .rst  (i_rst),
    .start(start),
    .speed(speed),
    .busy (conv_busy),
    .done (conv_done),
    .bcd  (bcd)
  );

  // Clear wins over increment; the counter saturates at LAP_MAX.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lap_count_reg <= '0;
    end else if (i_clear) begin
      lap_count_reg <= '0;
    end else if (i_lap_inc && (lap_count_reg != DIGIT_W'(LAP_MAX))) begin
      lap_count_reg <= lap_count_reg + DIGIT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lap_snap_reg   <= '0;
      level_snap_reg <= DIGIT_W'(1);
    end else if (start) begin
      lap_snap_reg   <= lap_count_reg;
      level_snap_reg <= level_code;
    end
  end

  assign hundred_blank = (bcd[11:8] == 4'd0);
  assign ten_blank     = hundred_blank && (bcd[7:4] == 4'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_reg       <= 1'b0;
      hundred_reg     <= BLANK_CODE;
      ten_reg         <= BLANK_CODE;
      one_reg         <= '0;
      lap_digit_reg   <= '0;
      level_digit_reg <= DIGIT_W'(1);
    end else begin
      valid_reg <= 1'b0;
      if (state_reg == ENC_DONE) begin
        valid_reg       <= 1'b1;
        hundred_reg     <= hundred_blank ? BLANK_CODE : DIGIT_W'(bcd[11:8]);
        ten_reg         <= ten_blank ? BLANK_CODE : DIGIT_W'(bcd[7:4]);
        one_reg         <= DIGIT_W'(bcd[3:0]);
        lap_digit_reg   <= lap_snap_reg;
        level_digit_reg <= level_snap_reg;
      end
    end
  end

  assign o_busy        = (state_reg != ENC_IDLE);
  assign o_valid       = valid_reg;
  assign o_vel_hundred = hundred_reg;
  assign o_vel_ten     = ten_reg;
  assign o_vel_one     = one_reg;
  assign o_lap_digit   = lap_digit_reg;
  assign o_level_digit = level_digit_reg;
  assign o_finished    = (lap_count_reg == DIGIT_W'(LAP_MAX));

endmodule

// File: tb/tb_bar_digit_encoder.sv
// Directed bench for bar_digit_encoder: default instance (shift 3) and a shift-0 instance,
// with a queue of expected frames checked when each o_valid pulse arrives.
module tb_bar_digit_encoder;

  typedef struct {
    int h;
    int t;
    int o;
    int lap;
    int lvl;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fs0 = 1'b0;
  logic       fs1 = 1'b0;
  logic [9:0] velocity = '0;
  logic [1:0] level = '0;
  logic       lap_inc = 1'b0;
  logic       clear = 1'b0;

  logic       busy0, valid0, fin0, busy1, valid1, fin1;
  logic [3:0] hundred0, ten0, one0, lap0, lvl0;
  logic [3:0] hundred1, ten1, one1, lap1, lvl1;

  int   errors = 0;
  int   checks = 0;
  int   lap_model = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bar_digit_encoder dut0 (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs0), .i_velocity(velocity), .i_level(level),
    .i_lap_inc(lap_inc), .i_clear(clear), .o_busy(busy0), .o_valid(valid0),
    .o_vel_hundred(hundred0), .o_vel_ten(ten0), .o_vel_one(one0),
    .o_lap_digit(lap0), .o_level_digit(lvl0), .o_finished(fin0)
  );

  bar_digit_encoder #(.VEL_SHIFT(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs1), .i_velocity(velocity), .i_level(level),
    .i_lap_inc(lap_inc), .i_clear(clear), .o_busy(busy1), .o_valid(valid1),
    .o_vel_hundred(hundred1), .o_vel_ten(ten1), .o_vel_one(one1),
    .o_lap_digit(lap1), .o_level_digit(lvl1), .o_finished(fin1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      $error("check %s", tag);
    end
  endtask

  // Reference: decimal digits of |velocity| / 2^shift, leading zeros blanked.
  function automatic exp_t model(input logic [9:0] vel, input int shift, input logic [1:0] lvl,
                                 input int lap);
    exp_t e;
    int v, spd, h, t;
    v   = vel[9] ? int'(vel) - 1024 : int'(vel);
    if (v < 0) v = -v;
    spd = v / (1 << shift);
    h   = spd / 100;
    t   = (spd / 10) % 10;
    e.h   = (h == 0) ? 15 : h;
    e.t   = (h == 0 && t == 0) ? 15 : t;
    e.o   = spd % 10;
    e.lap = lap;
    e.lvl = (lvl == 2'd3) ? 3 : int'(lvl) + 1;
    e.lat = (shift == 3) ? 8 : 11;
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy0), 0);
    check({tag, "_valid"}, int'(valid0), 0);
    check({tag, "_hundred"}, int'(hundred0), 15);
    check({tag, "_ten"}, int'(ten0), 15);
    check({tag, "_one"}, int'(one0), 0);
    check({tag, "_lap"}, int'(lap0), 0);
    check({tag, "_level"}, int'(lvl0), 1);
    check({tag, "_finished"}, int'(fin0), 0);
  endtask

  // One frame on the selected instance; retries re-pulse frame_start on conversion cycles 1..retries.
  task automatic run_frame(input int which, input logic [9:0] vel, input logic [1:0] lvl,
                           input bit inc, input int retries);
    exp_t e, got;
    int   pulses;
    bit   seen;
    bit   v;
    e = model(vel, (which == 0) ? 3 : 0, lvl, lap_model);
    sb.push_back(e);
    velocity = vel;
    level    = lvl;
    lap_inc  = inc;
    if (which == 0) fs0 = 1'b1; else fs1 = 1'b1;
    tick();
    fs0 = 1'b0;
    fs1 = 1'b0;
    lap_inc = 1'b0;
    if (inc && lap_model < 3) lap_model++;
    check("busy_after_capture", int'((which == 0) ? busy0 : busy1), 1);
    pulses = 0;
    seen   = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k <= retries) begin
        fs0      = 1'b1;
        velocity = 10'h040;
        level    = 2'd2;
      end else begin
        fs0 = 1'b0;
      end
      tick();
      v = (which == 0) ? valid0 : valid1;
      if (v) begin
        pulses++;
        if (!seen) begin
          seen = 1'b1;
          got  = sb.pop_front();
          $display("frame dut%0d vel=%h -> %h %h %h lap=%0d lvl=%0d at cycle %0d", which, vel,
                   (which == 0) ? hundred0 : hundred1, (which == 0) ? ten0 : ten1,
                   (which == 0) ? one0 : one1, (which == 0) ? lap0 : lap1,
                   (which == 0) ? lvl0 : lvl1, k);
          check("latency", k, got.lat);
          check("hundred", int'((which == 0) ? hundred0 : hundred1), got.h);
          check("ten", int'((which == 0) ? ten0 : ten1), got.t);
          check("one", int'((which == 0) ? one0 : one1), got.o);
          check("lap_digit", int'((which == 0) ? lap0 : lap1), got.lap);
          check("level_digit", int'((which == 0) ? lvl0 : lvl1), got.lvl);
          check("busy_at_valid", int'((which == 0) ? busy0 : busy1), 0);
        end
      end
      if (seen && k >= e.lat + 4) break;
    end
    fs0 = 1'b0;
    check("valid_seen", int'(seen), 1);
    check("valid_pulses", pulses, 1);
    if (!seen && sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic pulse_lap(input bit clr);
    lap_inc = 1'b1;
    clear   = clr;
    tick();
    lap_inc = 1'b0;
    clear   = 1'b0;
    if (clr) lap_model = 0;
    else if (lap_model < 3) lap_model++;
    check("finished", int'(fin0), (lap_model == 3) ? 1 : 0);
    check("finished_dut1", int'(fin1), (lap_model == 3) ? 1 : 0);
  endtask

  initial begin
    int stray;
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    run_frame(0, 10'h1C0, 2'd0, 1'b0, 0);
    run_frame(0, 10'h200, 2'd1, 1'b0, 0);
    run_frame(0, 10'h000, 2'd3, 1'b0, 0);
    run_frame(0, 10'h1FF, 2'd2, 1'b0, 0);
    run_frame(1, 10'h200, 2'd0, 1'b0, 0);
    run_frame(1, 10'h3FF, 2'd1, 1'b0, 0);

    for (int i = 0; i < 4; i++) pulse_lap(1'b0);
    run_frame(0, 10'h0C8, 2'd0, 1'b0, 0);
    pulse_lap(1'b1);
    run_frame(0, 10'h0C8, 2'd1, 1'b1, 0);
    run_frame(0, 10'h100, 2'd1, 1'b0, 0);

    run_frame(0, 10'h1C0, 2'd0, 1'b0, 5);

    // Abort a conversion with reset during its fourth shift cycle.
    velocity = 10'h1C0;
    level    = 2'd1;
    fs0      = 1'b1;
    tick();
    fs0 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    lap_model = 0;
    stray = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) rst = 1'b0;
      tick();
      if (valid0) stray++;
    end
    check("no_valid_after_abort", stray, 0);
    run_frame(0, 10'h3C0, 2'd2, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
